// File: rtl/ps2_held_key_tracker.sv
// Turns the PS/2 byte stream into a last-pressed-wins "currently held key" scan code.
// Handles F0 break and E0 extended prefixes; extended keys never enter the held-key stack.
module ps2_held_key_tracker #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [7:0]  IDLE_CODE = 8'h00
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] ps2_key_data,
    input  logic       ps2_key_pressed,
    output logic [7:0] note_select,
    output logic       note_active,
    output logic       note_change,
    output logic [3:0] held_count
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BRK     = 2'd1,
        S_EXT     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      stack_q [DEPTH];
    logic [7:0]      stack_d [DEPTH];
    logic [CW-1:0]   count_d;
    logic [DEPTH-1:0] hit;
    logic            do_make, do_break, seen;
    logic [7:0]      top_d;

    // Bytes that are protocol responses rather than keys
    function automatic logic is_ignored(input logic [7:0] code);
        case (code)
            8'h00, 8'hAA, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'hE1: is_ignored = 1'b1;
            default:                                                is_ignored = 1'b0;
        endcase
    endfunction

    // Prefix decoding, stack update and next output values
    always_comb begin
        state_d  = state_q;
        do_make  = 1'b0;
        do_break = 1'b0;
        stack_d  = stack_q;
        count_d  = held_count;
        seen     = 1'b0;
        top_d    = IDLE_CODE;

        if (ps2_key_pressed) begin
            case (state_q)
                S_IDLE: begin
                    if (ps2_key_data == 8'hF0)      state_d = S_BRK;
                    else if (ps2_key_data == 8'hE0) state_d = S_EXT;
                    else                            do_make = !is_ignored(ps2_key_data);
                end
                S_BRK: begin
                    do_break = !is_ignored(ps2_key_data);
                    state_d  = S_IDLE;
                end
                S_EXT: begin
                    state_d = (ps2_key_data == 8'hF0) ? S_EXT_BRK : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        for (int unsigned i = 0; i < DEPTH; i++) begin
            hit[i] = (CW'(i) < held_count) && (stack_q[i] == ps2_key_data);
        end

        if (do_make && (hit == '0)) begin
            if (held_count == CW'(DEPTH)) begin
                // Full: oldest entry falls off the bottom
                for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                    stack_d[i] = stack_q[i + 1];
                end
                stack_d[DEPTH-1] = ps2_key_data;
            end else begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == held_count) stack_d[i] = ps2_key_data;
                end
                count_d = held_count + CW'(1);
            end
        end else if (do_break && (hit != '0)) begin
            // Compact entries above the removed key down one slot
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (hit[i]) seen = 1'b1;
                if (seen) stack_d[i] = (i + 1 < DEPTH) ? stack_q[i + 1] : IDLE_CODE;
            end
            count_d = held_count - CW'(1);
        end

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i + 1) == count_d) top_d = stack_d[i];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            held_count  <= '0;
            note_select <= IDLE_CODE;
            note_active <= 1'b0;
            note_change <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) stack_q[i] <= IDLE_CODE;
        end else begin
            state_q     <= state_d;
            stack_q     <= stack_d;
            held_count  <= count_d;
            note_select <= top_d;
            note_active <= (count_d != '0);
            note_change <= (top_d != note_select);
        end
    end

endmodule

// File: tb/tb_ps2_held_key_tracker.sv
// Directed and randomized checks of ps2_held_key_tracker against a queue-based model.
module tb_ps2_held_key_tracker;

    localparam int unsigned DEPTH = 4;

    logic       clock;
    logic       resetn;
    logic [7:0] ps2_key_data;
    logic       ps2_key_pressed;
    logic [7:0] note_select;
    logic       note_active;
    logic       note_change;
    logic [3:0] held_count;

    int errors = 0;
    int checks = 0;

    // Reference model state: held keys oldest-first, plus pending prefix flags
    byte unsigned held_q[$];
    bit           brk_pending, ext_pending, ext_brk_pending;

    ps2_held_key_tracker #(.DEPTH(DEPTH), .IDLE_CODE(8'h00)) dut (
        .clock           (clock),
        .resetn          (resetn),
        .ps2_key_data    (ps2_key_data),
        .ps2_key_pressed (ps2_key_pressed),
        .note_select     (note_select),
        .note_active     (note_active),
        .note_change     (note_change),
        .held_count      (held_count)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit ignored(input byte unsigned b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFC) ||
               (b == 8'hFD) || (b == 8'hFE) || (b == 8'hFF) || (b == 8'hE1);
    endfunction

    function automatic byte unsigned model_top();
        return (held_q.size() > 0) ? held_q[held_q.size()-1] : 8'h00;
    endfunction

    function automatic void model_reset();
        held_q.delete();
        brk_pending     = 0;
        ext_pending     = 0;
        ext_brk_pending = 0;
    endfunction

    function automatic void model_byte(input byte unsigned b);
        int idx[$];
        idx = held_q.find_first_index(x) with (x == b);
        if (ext_brk_pending) begin
            ext_brk_pending = 0;
        end else if (ext_pending) begin
            ext_pending     = 0;
            ext_brk_pending = (b == 8'hF0);
        end else if (brk_pending) begin
            brk_pending = 0;
            if (!ignored(b) && idx.size() > 0) held_q.delete(idx[0]);
        end else if (b == 8'hF0) begin
            brk_pending = 1;
        end else if (b == 8'hE0) begin
            ext_pending = 1;
        end else if (!ignored(b) && idx.size() == 0) begin
            if (held_q.size() == DEPTH) void'(held_q.pop_front());
            held_q.push_back(b);
        end
    endfunction

    task automatic check_outputs(input string tag, input bit exp_change);
        check({tag, ".select"}, 32'(note_select), 32'(model_top()));
        check({tag, ".count"},  32'(held_count),  32'(held_q.size()));
        check({tag, ".active"}, 32'(note_active), 32'(held_q.size() != 0));
        check({tag, ".change"}, 32'(note_change), 32'(exp_change));
    endtask

    task automatic send(input byte unsigned b, input string tag);
        byte unsigned prev;
        prev = model_top();
        @(negedge clock);
        ps2_key_data    = b;
        ps2_key_pressed = 1'b1;
        @(posedge clock);
        model_byte(b);
        #1;
        ps2_key_pressed = 1'b0;
        ps2_key_data    = 8'h00;
        check_outputs(tag, model_top() != prev);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            check_outputs("idle", 1'b0);
        end
    endtask

    task automatic do_reset();
        @(posedge clock);
        #3;
        resetn = 1'b0;
        model_reset();
        #1;
        check_outputs("reset", 1'b0);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    byte unsigned pool[12] = '{8'h1C, 8'h1A, 8'h15, 8'h1D, 8'h24, 8'h2D,
                              8'h2C, 8'hF0, 8'hF0, 8'hE0, 8'hAA, 8'h00};

    initial begin
        resetn          = 1'b0;
        ps2_key_pressed = 1'b0;
        ps2_key_data    = 8'h00;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_outputs("por", 1'b0);
        @(negedge clock);
        resetn = 1'b1;

        // Single make then break
        send(8'h1C, "make1");
        idle(1);
        send(8'hF0, "brk_pfx");
        send(8'h1C, "brk1");

        // Fall back to still-held key
        send(8'h1C, "fb_a");
        send(8'h1A, "fb_b");
        send(8'hF0, "fb_pfx");
        send(8'h1A, "fb_brk");

        // Typematic repeats
        for (int k = 0; k < 5; k++) send(8'h1C, "repeat");
        do_reset();

        // Overflow drops oldest key
        send(8'h15, "ov0");
        send(8'h1D, "ov1");
        send(8'h24, "ov2");
        send(8'h2D, "ov3");
        send(8'h2C, "ov4");
        send(8'hF0, "ov_pfx");
        send(8'h15, "ov_brk_dropped");
        // Remove a middle entry: no note change
        send(8'hF0, "mid_pfx");
        send(8'h24, "mid_brk");
        do_reset();

        // Extended keys are discarded
        send(8'hE0, "ext");
        send(8'h75, "ext_make");
        send(8'hE0, "ext2");
        send(8'hF0, "ext_brk");
        send(8'h75, "ext_brk_code");
        send(8'hE1, "ignored");

        // Reset discards a pending break prefix
        send(8'hF0, "pend_pfx");
        do_reset();
        send(8'h1C, "after_reset_make");
        do_reset();

        // Randomized byte stream
        for (int n = 0; n < 600; n++) begin
            send(pool[$urandom_range(11, 0)], "rand");
            if ($urandom_range(3, 0) == 0) idle(1);
            if ($urandom_range(99, 0) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
